// File: rtl/fibo_sched_pkg.sv
// fibo_sched_pkg
//    Shared types and constants for the Fibonacci job scheduler.
//    - state_t : scheduler FSM states
//    - COUNT_W : width of a Fibonacci index
//    - DATA_W  : width of a Fibonacci result (results wrap mod 16)
//    - needs_calc() : indices 0 and 1 are answered without the calculator
package fibo_sched_pkg;

   localparam int COUNT_W = 4;
   localparam int DATA_W  = 4;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      ARM   = 3'd2,
      WAIT  = 3'd3,
      RESP  = 3'd4
   } state_t;

   // The calculator works on count-2, so it is only usable for count >= 2.
   function automatic logic needs_calc(input logic [COUNT_W-1:0] cnt);
      return (cnt >= 4'd2);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//    Purely combinational round-robin arbiter. Grants the first request at or
//    after last_grant_i+1 (mod N).
//    Ports:
//       req_i        : N request bits
//       last_grant_i : index granted most recently
//       en_i         : when low no grant is produced
//       gnt_o        : one-hot grant (all zero when disabled or no request)
//       gnt_id_o     : binary index of the granted request
module rr_arbiter #(
   parameter int N    = 4,
   parameter int ID_W = $clog2(N)
) (
   input  logic [N-1:0]    req_i,
   input  logic [ID_W-1:0] last_grant_i,
   input  logic            en_i,
   output logic [N-1:0]    gnt_o,
   output logic [ID_W-1:0] gnt_id_o
);

   int   idx_s;
   logic hit_s;
   logic found_s;

   // Scan from last_grant+1 around the ring; the first hit wins.
   always_comb begin
      gnt_o    = '0;
      gnt_id_o = '0;
      found_s  = 1'b0;
      idx_s    = 0;
      hit_s    = 1'b0;
      for (int k = 1; k <= N; k++) begin
         idx_s    = (int'(last_grant_i) + k) % N;
         hit_s    = en_i & ~found_s & req_i[idx_s[ID_W-1:0]];
         gnt_o[idx_s[ID_W-1:0]] = gnt_o[idx_s[ID_W-1:0]] | hit_s;
         gnt_id_o = hit_s ? idx_s[ID_W-1:0] : gnt_id_o;
         found_s  = found_s | hit_s;
      end
   end

endmodule

// File: rtl/fibo_job_scheduler.sv
// fibo_job_scheduler
//    Shares one Fibonacci calculator between N_REQ requesters. Requests are
//    round-robin arbitrated, the calculator start/done handshake is sequenced,
//    a watchdog aborts jobs that take too long, and results come back on a
//    single tagged response channel.
//    Ports:
//       clk_i, rst_i    : clock, asynchronous active-high reset
//       req_valid_i     : per-requester request
//       req_count_i     : per-requester index, slice i = [4*i+3:4*i]
//       req_ready_o     : one-hot grant, non-zero only in IDLE
//       rsp_valid_o     : response available, held until rsp_ready_i
//       rsp_id_o        : requester index of the response
//       rsp_data_o      : F(n) mod 16 (0 on timeout)
//       rsp_err_o       : job timed out
//       rsp_ready_i     : response consumer accepts
//       calc_start_o    : one-cycle start pulse to the calculator
//       calc_count_o    : index of the current/last job
//       calc_done_i     : calculator done level
//       calc_data_i     : calculator result
//       busy_o          : scheduler not idle
module fibo_job_scheduler
   import fibo_sched_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 64,
   parameter int ID_W    = $clog2(N_REQ)
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [N_REQ-1:0]         req_valid_i,
   input  logic [COUNT_W*N_REQ-1:0] req_count_i,
   output logic [N_REQ-1:0]         req_ready_o,
   output logic                     rsp_valid_o,
   output logic [ID_W-1:0]          rsp_id_o,
   output logic [DATA_W-1:0]        rsp_data_o,
   output logic                     rsp_err_o,
   input  logic                     rsp_ready_i,
   output logic                     calc_start_o,
   output logic [COUNT_W-1:0]       calc_count_o,
   input  logic                     calc_done_i,
   input  logic [DATA_W-1:0]        calc_data_i,
   output logic                     busy_o
);

   localparam int              WD_W    = $clog2(TIMEOUT);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   state_t              state_q,      state_d;
   logic [ID_W-1:0]     last_grant_q, last_grant_d;
   logic [ID_W-1:0]     job_id_q,     job_id_d;
   logic [COUNT_W-1:0]  job_cnt_q,    job_cnt_d;
   logic [DATA_W-1:0]   rsp_data_q,   rsp_data_d;
   logic                rsp_err_q,    rsp_err_d;
   logic [WD_W-1:0]     wdog_q,       wdog_d;
   logic                calc_start_q;
   logic                rsp_valid_q;
   logic                busy_q;

   logic                arb_en_s;
   logic [N_REQ-1:0]    gnt_s;
   logic [ID_W-1:0]     gnt_id_s;
   logic                hs_s;
   logic [COUNT_W-1:0]  sel_cnt_s;

   // Grants are only offered while idle and never while reset is asserted.
   assign arb_en_s = (state_q == IDLE) & ~rst_i;

   rr_arbiter #(
      .N    (N_REQ),
      .ID_W (ID_W)
   ) u_arb (
      .req_i        (req_valid_i),
      .last_grant_i (last_grant_q),
      .en_i         (arb_en_s),
      .gnt_o        (gnt_s),
      .gnt_id_o     (gnt_id_s)
   );

   assign req_ready_o = gnt_s;
   assign hs_s        = |(req_valid_i & gnt_s);

   // One-hot mux of the granted requester's index.
   always_comb begin
      sel_cnt_s = '0;
      for (int i = 0; i < N_REQ; i++) begin
         sel_cnt_s = sel_cnt_s | (req_count_i[COUNT_W*i +: COUNT_W] & {COUNT_W{gnt_s[i]}});
      end
   end

   // Next-state logic: job sequencing, watchdog and response capture.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      job_id_d     = job_id_q;
      job_cnt_d    = job_cnt_q;
      rsp_data_d   = rsp_data_q;
      rsp_err_d    = rsp_err_q;
      wdog_d       = wdog_q;
      case (state_q)
         IDLE: begin
            if (hs_s) begin
               job_cnt_d    = sel_cnt_s;
               job_id_d     = gnt_id_s;
               last_grant_d = gnt_id_s;
               if (needs_calc(sel_cnt_s)) begin
                  state_d = ISSUE;
               end else begin
                  // F(0)=0 and F(1)=1 equal the index itself.
                  state_d    = RESP;
                  rsp_data_d = DATA_W'(sel_cnt_s);
                  rsp_err_d  = 1'b0;
               end
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE: begin
            wdog_d  = '0;
            state_d = ARM;
         end
         ARM: begin
            // A done level left over from the previous job must drop first.
            if (wdog_q == WD_LAST) begin
               state_d    = RESP;
               rsp_data_d = '0;
               rsp_err_d  = 1'b1;
            end else begin
               wdog_d  = wdog_q + WD_W'(1);
               state_d = calc_done_i ? ARM : WAIT;
            end
         end
         WAIT: begin
            // Completion takes priority over a simultaneous timeout.
            if (calc_done_i) begin
               state_d    = RESP;
               rsp_data_d = calc_data_i;
               rsp_err_d  = 1'b0;
            end else if (wdog_q == WD_LAST) begin
               state_d    = RESP;
               rsp_data_d = '0;
               rsp_err_d  = 1'b1;
            end else begin
               wdog_d  = wdog_q + WD_W'(1);
               state_d = WAIT;
            end
         end
         RESP: begin
            state_d = rsp_ready_i ? IDLE : RESP;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, job and response registers; output flags are registered copies
   // of the next state so every output comes straight from a flop.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         last_grant_q <= ID_W'(N_REQ - 1);
         job_id_q     <= '0;
         job_cnt_q    <= '0;
         rsp_data_q   <= '0;
         rsp_err_q    <= 1'b0;
         wdog_q       <= '0;
         calc_start_q <= 1'b0;
         rsp_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         job_id_q     <= job_id_d;
         job_cnt_q    <= job_cnt_d;
         rsp_data_q   <= rsp_data_d;
         rsp_err_q    <= rsp_err_d;
         wdog_q       <= wdog_d;
         calc_start_q <= (state_d == ISSUE);
         rsp_valid_q  <= (state_d == RESP);
         busy_q       <= (state_d != IDLE);
      end
   end

   assign calc_start_o = calc_start_q;
   assign calc_count_o = job_cnt_q;
   assign rsp_valid_o  = rsp_valid_q;
   assign rsp_id_o     = job_id_q;
   assign rsp_data_o   = rsp_data_q;
   assign rsp_err_o    = rsp_err_q;
   assign busy_o       = busy_q;

endmodule

// File: tb/tb_fibo_job_scheduler.sv
// tb_fibo_job_scheduler
//    Self-checking bench: a cycle-timeline reference model predicts every
//    output each cycle, a behavioural calculator answers start pulses, and
//    directed plus random scenarios drive the requesters.
module tb_fibo_job_scheduler;

   localparam int N_REQ   = 4;
   localparam int TIMEOUT = 16;
   localparam int ID_W    = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [N_REQ-1:0]  req_valid = '0;
   logic [4*N_REQ-1:0] req_count = '0;
   logic              rsp_ready = 1'b0;
   logic              calc_done = 1'b0;
   logic [3:0]        calc_data = 4'd0;

   logic [N_REQ-1:0]  req_ready;
   logic              rsp_valid;
   logic [ID_W-1:0]   rsp_id;
   logic [3:0]        rsp_data;
   logic              rsp_err;
   logic              calc_start;
   logic [3:0]        calc_count;
   logic              busy;

   fibo_job_scheduler #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .req_valid_i  (req_valid),
      .req_count_i  (req_count),
      .req_ready_o  (req_ready),
      .rsp_valid_o  (rsp_valid),
      .rsp_id_o     (rsp_id),
      .rsp_data_o   (rsp_data),
      .rsp_err_o    (rsp_err),
      .rsp_ready_i  (rsp_ready),
      .calc_start_o (calc_start),
      .calc_count_o (calc_count),
      .calc_done_i  (calc_done),
      .calc_data_i  (calc_data),
      .busy_o       (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int nchecks = 0;
   int nerr    = 0;

   // calculator behaviour knobs (captured per job)
   int hang = 0;
   int lag  = 1;

   // reference model state
   bit m_busy = 1'b0;
   int m_last = N_REQ - 1;
   int m_cnt = 0, m_id = 0, m_hs = 0, m_rsp = 0, m_data = 0, m_err = 0;

   // calculator model state
   bit c_on = 1'b0;
   int c_s = 0, c_cnt = 0, c_hang = 0, c_lag = 1;

   // logs of what the DUT actually did
   int q_gnt[$];
   int q_id[$];
   int q_data[$];
   int q_err[$];
   int q_lat[$];
   int n_start = 0;
   int hs_cyc_dut = 0;
   int rise_cyc = 0;
   bit prev_v = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      nchecks++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int fib(input int n);
      int a = 0;
      int b = 1;
      int t;
      for (int i = 0; i < n; i++) begin
         t = (a + b) % 16;
         a = b;
         b = t;
      end
      return a;
   endfunction

   // first valid requester at or after last+1, as a one-hot mask
   function automatic int arb(input logic [N_REQ-1:0] v, input int last);
      int j;
      for (int k = 1; k <= N_REQ; k++) begin
         j = (last + k) % N_REQ;
         if (v[j]) return (1 << j);
      end
      return 0;
   endfunction

   // Compare process, reference model update and calculator model.
   always @(negedge clk) begin : model_cmp
      int exp_rdy;
      bit exp_v;
      int gid;
      if (rst) begin
         chk("rst_req_ready", int'(req_ready), 0);
         chk("rst_busy", int'(busy), 0);
         chk("rst_rsp_valid", int'(rsp_valid), 0);
         chk("rst_calc_start", int'(calc_start), 0);
         chk("rst_calc_count", int'(calc_count), 0);
         chk("rst_rsp_id", int'(rsp_id), 0);
         chk("rst_rsp_data", int'(rsp_data), 0);
         chk("rst_rsp_err", int'(rsp_err), 0);
         m_busy = 1'b0;
         m_last = N_REQ - 1;
         m_cnt  = 0;
         prev_v = 1'b0;
      end else begin
         exp_rdy = m_busy ? 0 : arb(req_valid, m_last);
         exp_v   = m_busy && (cyc >= m_rsp);
         chk("req_ready", int'(req_ready), exp_rdy);
         chk("busy", int'(busy), int'(m_busy));
         chk("rsp_valid", int'(rsp_valid), int'(exp_v));
         if (exp_v) begin
            chk("rsp_id", int'(rsp_id), m_id);
            chk("rsp_data", int'(rsp_data), m_data);
            chk("rsp_err", int'(rsp_err), m_err);
         end
         chk("calc_start", int'(calc_start), int'(m_busy && m_cnt >= 2 && cyc == m_hs + 1));
         chk("calc_count", int'(calc_count), m_cnt);

         // log observed DUT behaviour
         if ((req_valid & req_ready) != '0) begin
            gid = 0;
            for (int i = 0; i < N_REQ; i++) if (req_ready[i]) gid = i;
            q_gnt.push_back(gid);
            hs_cyc_dut = cyc;
         end
         if (rsp_valid && !prev_v) rise_cyc = cyc;
         if (rsp_valid && rsp_ready) begin
            q_id.push_back(int'(rsp_id));
            q_data.push_back(int'(rsp_data));
            q_err.push_back(int'(rsp_err));
            q_lat.push_back(rise_cyc - hs_cyc_dut);
         end
         prev_v = rsp_valid;
         if (calc_start) n_start++;

         // advance the model
         if (exp_v && rsp_ready) begin
            m_busy = 1'b0;
         end else if (!m_busy && (req_valid & exp_rdy[N_REQ-1:0]) != '0) begin
            for (int i = 0; i < N_REQ; i++) if (exp_rdy[i]) m_id = i;
            m_busy = 1'b1;
            m_last = m_id;
            m_hs   = cyc;
            m_cnt  = int'(req_count[4*m_id +: 4]);
            if (m_cnt < 2) begin
               m_rsp = cyc + 1;  m_data = m_cnt;       m_err = 0;
            end else if (hang != 0 || m_cnt + 3 > TIMEOUT) begin
               m_rsp = cyc + TIMEOUT + 2; m_data = 0;  m_err = 1;
            end else begin
               m_rsp = cyc + m_cnt + 5; m_data = fib(m_cnt); m_err = 0;
            end
         end
      end

      // calculator: done drops lag cycles after start, rises count+3 after
      if (calc_start) begin
         c_on = 1'b1; c_s = cyc; c_cnt = int'(calc_count); c_hang = hang; c_lag = lag;
      end
      if (c_on && cyc >= c_s + c_lag) begin
         if (c_hang == 0 && cyc >= c_s + c_cnt + 3) begin
            calc_done = 1'b1;
            calc_data = 4'(fib(c_cnt));
         end else begin
            calc_done = 1'b0;
         end
      end
   end

   task automatic request(input int id, input int cnt);
      req_count[4*id +: 4] = cnt[3:0];
      req_valid[id] = 1'b1;
   endtask

   // run n cycles, withdrawing each request once it has been granted
   task automatic cycles(input int n);
      logic [N_REQ-1:0] hs;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         hs = req_valid & req_ready;
         @(posedge clk);
         #1;
         req_valid = req_valid & ~hs;
      end
   endtask

   task automatic drain(input int budget);
      int k = 0;
      while (req_valid != '0 && k < budget) begin
         cycles(1);
         k++;
      end
      if (req_valid != '0) begin
         nchecks++; nerr++;
         $display("FAIL drain: requests %0h still pending, expected none", req_valid);
      end
   endtask

   task automatic wait_rsp(input int n, input int budget);
      int k = 0;
      while (q_data.size() < n && k < budget) begin
         @(posedge clk);
         k++;
      end
      #1;
      if (q_data.size() < n) begin
         nchecks++; nerr++;
         $display("FAIL wait_rsp: got %0d responses, expected %0d", q_data.size(), n);
      end
   endtask

   task automatic clear_logs();
      q_gnt.delete(); q_id.delete(); q_data.delete(); q_err.delete(); q_lat.delete();
      n_start = 0;
   endtask

   initial begin
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      rsp_ready = 1'b1;

      // round-robin from reset: 0, 1, 3
      clear_logs();
      request(0, 5); request(1, 6); request(3, 8);
      drain(200); wait_rsp(3, 200);
      chk("rr_gnt0", q_gnt[0], 0); chk("rr_gnt1", q_gnt[1], 1); chk("rr_gnt2", q_gnt[2], 3);
      chk("rr_data0", q_data[0], 5); chk("rr_data1", q_data[1], 8); chk("rr_data2", q_data[2], 5);

      // single job
      clear_logs();
      request(2, 7); drain(50); wait_rsp(1, 100);
      chk("single_id", q_id[0], 2); chk("single_data", q_data[0], 13);
      chk("single_err", q_err[0], 0); chk("single_starts", n_start, 1);
      chk("single_lat", q_lat[0], 12);

      // short-circuit
      clear_logs();
      request(1, 0); drain(50); wait_rsp(1, 50);
      request(1, 1); drain(50); wait_rsp(2, 50);
      chk("short_data0", q_data[0], 0); chk("short_data1", q_data[1], 1);
      chk("short_lat0", q_lat[0], 1); chk("short_lat1", q_lat[1], 1);
      chk("short_starts", n_start, 0);

      // stale done: done from previous job lingers three cycles
      clear_logs();
      lag = 3;
      request(0, 4); request(1, 9); drain(100); wait_rsp(2, 200);
      lag = 1;
      chk("stale_data0", q_data[0], 3); chk("stale_data1", q_data[1], 2);
      chk("stale_lat1", q_lat[1], 14);

      // timeout, then normal job
      clear_logs();
      hang = 1;
      request(3, 5); drain(50); wait_rsp(1, 100);
      hang = 0;
      chk("to_err", q_err[0], 1); chk("to_data", q_data[0], 0); chk("to_lat", q_lat[0], 18);
      request(3, 6); drain(50); wait_rsp(2, 100);
      chk("after_to_data", q_data[1], 8); chk("after_to_err", q_err[1], 0);

      // watchdog boundary: 13 completes on the last cycle, 14 times out
      clear_logs();
      request(2, 13); drain(50); wait_rsp(1, 100);
      request(2, 14); drain(50); wait_rsp(2, 100);
      chk("bnd13_data", q_data[0], 9); chk("bnd13_err", q_err[0], 0); chk("bnd13_lat", q_lat[0], 18);
      chk("bnd14_data", q_data[1], 0); chk("bnd14_err", q_err[1], 1); chk("bnd14_lat", q_lat[1], 18);

      // back-pressure
      clear_logs();
      rsp_ready = 1'b0;
      request(0, 3); request(1, 2);
      cycles(20);
      chk("bp_no_rsp", q_data.size(), 0);
      chk("bp_req1_waiting", int'(req_valid[1]), 1);
      rsp_ready = 1'b1;
      drain(100); wait_rsp(2, 100);
      chk("bp_data0", q_data[0], 2); chk("bp_data1", q_data[1], 1);

      // asynchronous reset in WAIT
      clear_logs();
      request(2, 10); drain(50);
      cycles(3);
      #2 rst = 1'b1;
      #1;
      chk("ar_busy", int'(busy), 0); chk("ar_rsp_valid", int'(rsp_valid), 0);
      chk("ar_calc_start", int'(calc_start), 0); chk("ar_calc_count", int'(calc_count), 0);
      chk("ar_rsp_id", int'(rsp_id), 0); chk("ar_rsp_data", int'(rsp_data), 0);
      chk("ar_rsp_err", int'(rsp_err), 0);
      request(3, 1); request(0, 2);
      #1;
      chk("ar_req_ready", int'(req_ready), 0);
      @(posedge clk); #1 rst = 1'b0;
      clear_logs();
      drain(100); wait_rsp(2, 100);
      chk("ar_next_gnt0", q_gnt[0], 0); chk("ar_next_gnt1", q_gnt[1], 3);
      chk("ar_data0", q_data[0], 1); chk("ar_data1", q_data[1], 1);

      // random traffic against the model
      clear_logs();
      for (int t = 0; t < 600; t++) begin
         for (int i = 0; i < N_REQ; i++) begin
            if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
               request(i, int'($urandom_range(0, 15)));
            end else if (req_valid[i] && $urandom_range(0, 15) == 0) begin
               req_valid[i] = 1'b0;
            end
         end
         rsp_ready = ($urandom_range(0, 2) != 0);
         lag = int'($urandom_range(1, 3));
         cycles(1);
      end
      rsp_ready = 1'b1;
      lag = 1;
      drain(400);
      cycles(40);
      chk("rand_progress", int'(q_data.size() > 10), 1);

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation still running at %0t, expected finish", $time);
      $fatal(1, "simulation time limit reached");
   end

endmodule
